// File: rtl/srt4_host_seq.sv
// Command FIFO and sequencer feeding the srt4 divider's serial operand protocol.
// Build option: SRT4_SEQ_DIVZERO_BYPASS_EN answers zero-divisor commands without using the divider.
module srt4_host_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_dividend,
  input  logic [7:0] cmd_divisor,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_quotient,
  output logic [7:0] rsp_remainder,
  output logic [1:0] rsp_err,
  output logic [7:0] div_inbus,
  output logic       div_begin,
  output logic       div_rst_b,
  input  logic [7:0] div_outbus,
  input  logic       div_end,
  output logic [2:0] dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] TO_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_READ_R, S_RECOVER, S_RESP
  } state_t;

  state_t state, state_nx;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_ne_q;
  logic          push, pop;
  logic [7:0]    head_a, head_b;
  logic [7:0]    op_a, op_b, q_hold, cnt;
  logic          rst_d;
  logic          ld_rsp;
  logic [7:0]    nx_q, nx_r;
  logic [1:0]    nx_err;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid & ready are
  // both high; the producer holds valid and its data stable until that edge.
  assign cmd_ready = (count != DEPTH_C);
  assign push      = cmd_valid & cmd_ready;
  assign head_a    = mem[rd_ptr][15:8];
  assign head_b    = mem[rd_ptr][7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_dividend, cmd_divisor};
  end

  // fifo_ne_q lags the count by one cycle, giving the two-cycle push-to-LOAD_A latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_ne_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      fifo_ne_q <= (count != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    ld_rsp   = 1'b0;
    nx_q     = 8'h00;
    nx_r     = 8'h00;
    nx_err   = 2'd0;
    case (state)
      S_IDLE: begin
        if (fifo_ne_q) begin
          pop = 1'b1;
`ifdef SRT4_SEQ_DIVZERO_BYPASS_EN
          if (head_b == 8'd0) begin
            state_nx = S_RESP;
            ld_rsp   = 1'b1;
            nx_q     = 8'hFF;
            nx_r     = head_a;
            nx_err   = 2'd1;
          end else begin
            state_nx = S_LOAD_A;
          end
`else
          state_nx = S_LOAD_A;
`endif
        end
      end
      S_LOAD_A: state_nx = S_LOAD_B;
      S_LOAD_B: state_nx = S_WAIT;
      S_WAIT: begin
        // Completion takes priority over the timeout limit in the same cycle.
        if (div_end)          state_nx = S_READ_R;
        else if (cnt == TO_C) state_nx = S_RECOVER;
      end
      S_READ_R: begin
        state_nx = S_RESP;
        ld_rsp   = 1'b1;
        nx_q     = q_hold;
        nx_r     = div_outbus;
      end
      S_RECOVER: begin
        if (cnt == 8'd1) begin
          state_nx = S_RESP;
          ld_rsp   = 1'b1;
          nx_err   = 2'd2;
        end
      end
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // cnt counts cycles spent in WAIT (timeout) and in RECOVER (reset pulse width).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if ((state == S_WAIT || state == S_RECOVER) && state_nx == state) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a          <= 8'h00;
      op_b          <= 8'h00;
      q_hold        <= 8'h00;
      rsp_quotient  <= 8'h00;
      rsp_remainder <= 8'h00;
      rsp_err       <= 2'd0;
      rst_d         <= 1'b1;
    end else begin
      rst_d <= 1'b0;
      if (pop) begin
        op_a <= head_a;
        op_b <= head_b;
      end
      if (state == S_WAIT && div_end) q_hold <= div_outbus;
      if (ld_rsp) begin
        rsp_quotient  <= nx_q;
        rsp_remainder <= nx_r;
        rsp_err       <= nx_err;
      end
    end
  end

  always_comb begin
    div_inbus = 8'h00;
    case (state)
      S_LOAD_A:                  div_inbus = op_a;
      S_LOAD_B, S_WAIT, S_READ_R: div_inbus = op_b;
      default:                   ;
    endcase
  end

  assign div_begin = (state == S_LOAD_A);
  assign div_rst_b = ~(rst | rst_d | (state == S_RECOVER));
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

endmodule

// File: tb/tb_srt4_host_seq.sv
// Bench for srt4_host_seq: behavioural divider model, scoreboard of expected responses, directed + random stimulus.
module tb_srt4_host_seq;
  localparam int DEPTH = 4;
  localparam int TO    = 64;
`ifdef SRT4_SEQ_DIVZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_dividend = 8'h00;
  logic [7:0] cmd_divisor = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_quotient, rsp_remainder;
  logic [1:0] rsp_err;
  logic [7:0] div_inbus;
  logic       div_begin, div_rst_b;
  logic [7:0] div_outbus = 8'h00;
  logic       div_end = 1'b0;
  logic [2:0] dbg_state;

  srt4_host_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dividend(cmd_dividend), .cmd_divisor(cmd_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_inbus(div_inbus), .div_begin(div_begin), .div_rst_b(div_rst_b),
    .div_outbus(div_outbus), .div_end(div_end), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];   // {err, quotient, remainder}
  int lat_q[$];            // divider latency for each command that reaches the divider
  int ready_mode = 1;      // 0: hold off, 1: always ready, 2: random
  int stray_cyc = -1;
  int rsp_cnt = 0;
  int begin_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ref_rsp(input logic [7:0] a, input logic [7:0] b, input int lat);
    logic [7:0] q, r;
    if (BYP && b == 8'd0) return {2'd1, 8'hFF, a};
    if (b == 8'd0 || lat > TO) return {2'd2, 16'h0000};
    q = a / b;
    r = a % b;
    return {2'd0, q, r};
  endfunction

  // ---------------- behavioural divider ----------------
  int ph = 0, mcnt = 0, mlat = 0;
  logic [7:0] ma = 8'h00, mb = 8'h00;
  always @(posedge clk) begin
    #1;
    if (!div_rst_b) begin
      ph = 0; div_end = 1'b0; div_outbus = 8'h00;
    end else begin
      case (ph)
        0: begin
          if (div_begin) begin
            ma = div_inbus;
            mlat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            ph = 1;
          end
          div_end = (cyc == stray_cyc);
          div_outbus = div_end ? 8'hAA : 8'h00;
        end
        1: begin mb = div_inbus; mcnt = 0; ph = 2; end
        2: begin
          if (mb != 8'd0 && mcnt == mlat) begin
            div_end = 1'b1; div_outbus = ma / mb; ph = 3;
          end else mcnt++;
        end
        3: begin div_outbus = ma % mb; ph = 4; end
        default: begin div_end = 1'b0; div_outbus = 8'h00; ph = 0; end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rsp_ready = 1'b0;
      1: rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- response monitor ----------------
  logic prev_end = 1'b0, prev_valid = 1'b0;
  int t_end = -1;
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      t_end = -1;
    end else begin
      if (div_begin) begin begin_cnt++; t_end = -1; end
      if (div_end && !prev_end && ph == 3) t_end = cyc;
      if (rsp_valid && !prev_valid && t_end >= 0) begin
        chk("rsp_latency", cyc - t_end, 2);
        t_end = -1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_quotient", rsp_quotient, e[15:8]);
          chk("rsp_remainder", rsp_remainder, e[7:0]);
          chk("rsp_err", rsp_err, e[17:16]);
        end
      end
    end
    prev_end = div_end;
    prev_valid = rsp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b, input int lat);
    bit done = 0;
    cmd_dividend = a; cmd_divisor = b; cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (done) begin
      exp_q.push_back(ref_rsp(a, b, lat));
      if (!(BYP && b == 8'd0)) lat_q.push_back(lat);
    end else chk("push_accept", 0, 1);
  endtask

  task automatic drain(input int max);
    int i = 0;
    while (exp_q.size() != 0 && i < max) begin @(posedge clk); i++; end
    #1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_begin(output bit seen);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (div_begin) seen = 1;
    end
    if (!seen) chk("begin_seen", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int n, lows, base, busy;
    logic [7:0] a, b;
    int lat;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_quotient", rsp_quotient, 0);
    chk("rst_remainder", rsp_remainder, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_div_begin", div_begin, 0);
    chk("rst_div_inbus", div_inbus, 0);
    chk("rst_div_rst_b", div_rst_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_b_hold", div_rst_b, 0);
    @(negedge clk);
    chk("rst_b_release", div_rst_b, 1);
    @(posedge clk); #1;

    // Single operation with exact handshake timing.
    push(8'd202, 8'd7, 10);
    @(negedge clk); chk("la_early0", div_begin, 0);
    @(negedge clk); chk("la_early1", div_begin, 0);
    @(negedge clk);
    chk("la_begin", div_begin, 1);
    chk("la_inbus", div_inbus, 202);
    @(negedge clk);
    chk("lb_begin", div_begin, 0);
    chk("lb_inbus", div_inbus, 7);
    @(negedge clk); chk("wait_inbus", div_inbus, 7);
    drain(200);
    chk("idle_inbus", div_inbus, 0);

    // Backpressure: one in flight plus a full FIFO.
    ready_mode = 0;
    base = rsp_cnt;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), $urandom_range(0, 12));
    @(negedge clk); chk("full_cmd_ready", cmd_ready, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_hold_ready", cmd_ready, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    ready_mode = 1;
    drain(1000);
    chk("bp_rsp_count", rsp_cnt - base, 5);

    // Divide by zero: bypass answers in two cycles, otherwise the silent divider times out.
    base = begin_cnt;
    push(8'd100, 8'd0, 5);
    repeat (3) @(negedge clk);
    chk("dz_rsp_at2", rsp_valid, BYP);
    drain(300);
    chk("dz_begin_count", begin_cnt - base, BYP ? 0 : 1);

    // Timeout, recovery pulse, then a normal command and the simultaneous boundary.
    push(8'd9, 8'd2, TO + 1);
    wait_begin(seen);
    n = 0; lows = 0;
    for (int i = 1; i < 200 && n == 0; i++) begin
      @(negedge clk);
      if (!div_rst_b) lows++;
      if (rsp_valid) n = i;
    end
    chk("to_latency", n, TO + 5);
    chk("to_rst_b_lows", lows, 2);
    @(posedge clk); #1;
    push(8'd50, 8'd3, 5);
    push(8'd77, 8'd5, TO);
    drain(600);

    // Stray div_end while idle is ignored.
    stray_cyc = cyc + 2;
    busy = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid) busy++; end
    chk("stray_no_rsp", busy, 0);
    @(posedge clk); #1;

    // Reset while an operation waits with two more queued.
    push(8'd11, 8'd3, 40);
    push(8'd12, 8'd3, 40);
    push(8'd13, 8'd3, 40);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_div_rst_b", div_rst_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    busy = 0;
    repeat (30) begin @(negedge clk); if (rsp_valid) busy++; end
    chk("post_rst_no_rsp", busy, 0);
    @(posedge clk); #1;
    push(8'd50, 8'd3, 3);
    drain(200);

    // Randomized traffic with random consumer backpressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      lat = ($urandom_range(0, 9) == 0) ? TO + 1 + $urandom_range(0, 3) : $urandom_range(0, 20);
      push(a, b, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain(20000);
    ready_mode = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
